// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//
// Two-requester arbiter in front of a single-command SDRAM controller.
// Requester 0 is normally the CPU and requester 1 is a DMA or video engine.
// Only one transaction is in flight at a time. The winner's command is latched
// on the grant edge and stays frozen until the controller completes it.
//
// Transaction flow (IDLE -> BUSY -> RESP -> IDLE):
//   IDLE : pick a winner among the valid requesters and latch its command.
//   BUSY : present s_valid until the controller answers with s_ready, then
//          capture s_dout for the granted requester.
//   RESP : the granted requester sees its one-cycle ready pulse, and the
//          last-granted pointer moves to it. No arbitration takes place here,
//          so there is always one IDLE cycle between transactions.
//
// Parameters
//   ADDR_WIDTH : word-address width of the requester and controller ports
//   PRIO_M0    : 1 = m0 always wins a tie, 0 = round-robin on ties
//
// Ports
//   clk, resetn                     : clock, asynchronous active-low reset
//   m{0,1}_valid/addr/wdata/wstrb   : requester command (wstrb 0 = read)
//   m{0,1}_ready/rdata              : completion pulse and read data
//   s_valid/s_addr/s_din/s_wmask    : command to the SDRAM controller
//   s_ready/s_dout                  : controller completion and read data
//   grant                           : index of the requester owning the bus
//   busy                            : high while a transaction is open
// -----------------------------------------------------------------------------
module sdram_arbiter #(
  parameter int ADDR_WIDTH = 21,
  parameter int PRIO_M0    = 0
) (
  input  logic                  clk,
  input  logic                  resetn,

  input  logic                  m0_valid,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic                  m0_ready,
  output logic [31:0]           m0_rdata,

  input  logic                  m1_valid,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_ready,
  output logic [31:0]           m1_rdata,

  output logic                  s_valid,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [31:0]           s_din,
  output logic [3:0]            s_wmask,
  input  logic                  s_ready,
  input  logic [31:0]           s_dout,

  output logic                  grant,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state_q,   state_d;
  logic                  grant_q,   grant_d;
  logic                  last_q,    last_d;
  logic [ADDR_WIDTH-1:0] s_addr_q,  s_addr_d;
  logic [31:0]           s_din_q,   s_din_d;
  logic [3:0]            s_wmask_q, s_wmask_d;

  // The requester ports are gathered into arrays so that the response logic
  // below can be written once for both requesters.
  logic [1:0]            req_valid;
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [31:0]           req_wdata [2];
  logic [3:0]            req_wstrb [2];
  logic [1:0]            rsp_ready;
  logic [31:0]           rsp_rdata [2];

  logic                  winner;
  logic                  complete;

  assign req_valid    = {m1_valid, m0_valid};
  assign req_addr[0]  = m0_addr;
  assign req_addr[1]  = m1_addr;
  assign req_wdata[0] = m0_wdata;
  assign req_wdata[1] = m1_wdata;
  assign req_wstrb[0] = m0_wstrb;
  assign req_wstrb[1] = m1_wstrb;

  // Winner selection. The result is used only in IDLE.
  // On a tie, round-robin picks the requester that was not granted last.
  // A single valid requester always wins, whatever the pointer holds.
  always_comb begin
    winner = 1'b0;
    if (&req_valid) begin
      winner = (PRIO_M0 != 0) ? 1'b0 : ~last_q;
    end else begin
      winner = req_valid[1];
    end
  end

  // The controller finishes the open command in this cycle.
  // An s_ready seen outside BUSY never sets this signal, so it is ignored.
  assign complete = (state_q == ST_BUSY) && s_ready;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    s_addr_d  = s_addr_q;
    s_din_d   = s_din_q;
    s_wmask_d = s_wmask_q;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          state_d   = ST_BUSY;
          grant_d   = winner;
          s_addr_d  = req_addr[winner];
          s_din_d   = req_wdata[winner];
          s_wmask_d = req_wstrb[winner];
        end
      end
      ST_BUSY: begin
        // The command is not touched here. A requester that changes its
        // inputs, or drops valid, cannot disturb the open transaction.
        if (s_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        last_d  = grant_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      // After reset the pointer reads "m1 was granted last", so m0 wins the
      // first tie.
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_addr_q  <= '0;
      s_din_q   <= '0;
      s_wmask_q <= '0;
    end else begin
      s_addr_q  <= s_addr_d;
      s_din_q   <= s_din_d;
      s_wmask_q <= s_wmask_d;
    end
  end

  // Response path for each requester. The ready flop is set on the completing
  // edge, so it is high for exactly the RESP cycle. The rdata register loads
  // only for the granted requester, so the other requester keeps its last
  // read value.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mine;

    assign mine    = complete && (grant_q == 1'(gi));
    assign ready_d = mine;
    assign rdata_d = mine ? s_dout : rdata_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        ready_q <= 1'b0;
        rdata_q <= '0;
      end else begin
        ready_q <= ready_d;
        rdata_q <= rdata_d;
      end
    end

    assign rsp_ready[gi] = ready_q;
    assign rsp_rdata[gi] = rdata_q;
  end

  // s_valid is dropped in the same cycle that s_ready arrives. The controller
  // therefore never sees the finished command as a new request.
  assign s_valid  = (state_q == ST_BUSY) && !s_ready;
  assign s_addr   = s_addr_q;
  assign s_din    = s_din_q;
  assign s_wmask  = s_wmask_q;
  assign grant    = grant_q;
  assign busy     = (state_q != ST_IDLE);

  assign m0_ready = rsp_ready[0];
  assign m1_ready = rsp_ready[1];
  assign m0_rdata = rsp_rdata[0];
  assign m1_rdata = rsp_rdata[1];

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//
// Bench for sdram_arbiter. It runs two instances on shared stimulus: one in
// round-robin mode and one in fixed-priority mode. The round-robin instance
// is checked throughout. The fixed-priority instance is checked after reset
// and during the simultaneous-request scenario.
//
// Expected values come from a transaction-level model: a last-granted bit, a
// copy of each requester's pending command, and each requester's expected
// rdata.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          m0_valid = 1'b0, m1_valid = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [31:0]   m0_wdata = '0, m1_wdata = '0;
  logic [3:0]    m0_wstrb = '0, m1_wstrb = '0;
  logic          s_ready = 1'b0;
  logic [31:0]   s_dout = '0;

  logic          m0_ready, m1_ready, s_valid, grant, busy;
  logic [31:0]   m0_rdata, m1_rdata, s_din;
  logic [AW-1:0] s_addr;
  logic [3:0]    s_wmask;

  logic          fp_m0_ready, fp_m1_ready, fp_s_valid, fp_grant, fp_busy;
  logic [31:0]   fp_m0_rdata, fp_m1_rdata, fp_s_din;
  logic [AW-1:0] fp_s_addr;
  logic [3:0]    fp_s_wmask;

  sdram_arbiter #(.ADDR_WIDTH(AW), .PRIO_M0(0)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_din(s_din), .s_wmask(s_wmask),
    .s_ready(s_ready), .s_dout(s_dout), .grant(grant), .busy(busy)
  );

  sdram_arbiter #(.ADDR_WIDTH(AW), .PRIO_M0(1)) dut_fp (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
    .s_valid(fp_s_valid), .s_addr(fp_s_addr), .s_din(fp_s_din), .s_wmask(fp_s_wmask),
    .s_ready(s_ready), .s_dout(s_dout), .grant(fp_grant), .busy(fp_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit            exp_last;
  logic [31:0]   exp_rdata [2];
  logic [AW-1:0] req_addr  [2];
  logic [31:0]   req_wdata [2];
  logic [3:0]    req_wstrb [2];

  typedef struct {
    logic          g, fp_g, sv_first, sv_busy, sv_at_s, early_rdy, cmd_hold;
    logic          r0, r1, busy_resp, r0_after, r1_after, busy_idle, sv_idle;
    logic [AW-1:0] addr_first, addr_last;
    logic [31:0]   din_first, din_last, rd0, rd1;
    logic [3:0]    wm_first, wm_last;
  } obs_t;

  // Tie goes to the requester not granted last, or to m0 under fixed
  // priority. A single request wins outright.
  function automatic bit pick(bit v0, bit v1, bit last, bit prio);
    if (v0 && v1) return prio ? 1'b0 : !last;
    return v1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    m0_addr = req_addr[0]; m0_wdata = req_wdata[0]; m0_wstrb = req_wstrb[0];
    m1_addr = req_addr[1]; m1_wdata = req_wdata[1]; m1_wstrb = req_wstrb[1];
  endtask

  task automatic new_req(input int k);
    req_addr[k]  = AW'($urandom);
    req_wdata[k] = $urandom;
    req_wstrb[k] = 4'($urandom);
    if (k == 0) m0_valid = 1'b1; else m1_valid = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    exp_last = 1'b1; exp_rdata[0] = '0; exp_rdata[1] = '0;
  endtask

  // Runs one transaction from an IDLE cycle, acting as the controller.
  // It records what the DUT shows at each stage. The requester inputs are
  // scrambled during BUSY and restored before completion. Each requester drops
  // valid when it sees its own ready.
  task automatic txn(input int lat, input logic [31:0] dout, input bit drop, output obs_t o);
    drive_reqs();
    tick();
    o.g = grant; o.fp_g = fp_grant; o.sv_first = s_valid; o.sv_busy = s_valid;
    o.addr_first = s_addr; o.din_first = s_din; o.wm_first = s_wmask;
    o.early_rdy = m0_ready | m1_ready; o.cmd_hold = 1'b1;
    if (drop) begin m0_valid = 1'b0; m1_valid = 1'b0; end
    for (int i = 0; i < lat; i++) begin
      m0_addr = AW'($urandom); m1_addr = AW'($urandom);
      m0_wdata = $urandom; m1_wdata = $urandom;
      m0_wstrb = 4'($urandom); m1_wstrb = 4'($urandom);
      tick();
      o.sv_busy   = o.sv_busy & s_valid;
      o.early_rdy = o.early_rdy | m0_ready | m1_ready;
      if ({s_addr, s_din, s_wmask} !== {o.addr_first, o.din_first, o.wm_first}) o.cmd_hold = 1'b0;
    end
    drive_reqs();
    s_ready = 1'b1; s_dout = dout;
    #1;
    o.sv_at_s = s_valid; o.addr_last = s_addr; o.din_last = s_din; o.wm_last = s_wmask;
    o.early_rdy = o.early_rdy | m0_ready | m1_ready;
    tick();
    s_ready = 1'b0; s_dout = $urandom;
    o.r0 = m0_ready; o.r1 = m1_ready; o.rd0 = m0_rdata; o.rd1 = m1_rdata; o.busy_resp = busy;
    if (m0_ready === 1'b1) m0_valid = 1'b0;
    if (m1_ready === 1'b1) m1_valid = 1'b0;
    tick();
    o.r0_after = m0_ready; o.r1_after = m1_ready; o.busy_idle = busy; o.sv_idle = s_valid;
  endtask

  task automatic test_reset();
    #1; resetn = 1'b0; #1;
    n_checks++;
    if ({s_valid, busy, grant, m0_ready, m1_ready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got sv/busy/grant/r0/r1=%b expected 00000", {s_valid, busy, grant, m0_ready, m1_ready});
    end
    n_checks++;
    if ({s_addr, s_din, s_wmask, m0_rdata, m1_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_data: got addr=%h din=%h wm=%h rd0=%h rd1=%h expected all 0", s_addr, s_din, s_wmask, m0_rdata, m1_rdata);
    end
    n_checks++;
    if ({fp_s_valid, fp_busy, fp_grant, fp_m0_ready, fp_m1_ready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_fp_ctrl: got %b expected 00000", {fp_s_valid, fp_busy, fp_grant, fp_m0_ready, fp_m1_ready});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    tick();
    n_checks++;
    if ({s_valid, busy, grant} !== 3'b0) begin
      n_fail++; $display("FAIL reset_release: got sv/busy/grant=%b expected 000", {s_valid, busy, grant});
    end
    exp_last = 1'b1; exp_rdata[0] = '0; exp_rdata[1] = '0;
    $display("reset: checked outputs during and after reset");
  endtask

  task automatic test_idle();
    logic bad;
    bad = 1'b0;
    repeat (20) begin
      tick();
      if ({s_valid, busy, m0_ready, m1_ready} !== 4'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL idle_quiet: activity seen with no requests (last sv=%b busy=%b) expected none", s_valid, busy);
    end
    $display("idle: 20 cycles with no requests");
  endtask

  task automatic test_single_read();
    obs_t o;
    bit w;
    req_addr[0] = 21'h00010; req_wdata[0] = $urandom; req_wstrb[0] = 4'b0000;
    m0_valid = 1'b1; m1_valid = 1'b0;
    w = pick(1'b1, 1'b0, exp_last, 1'b0);
    txn(3, 32'hDEADBEEF, 1'b0, o);
    exp_rdata[w] = 32'hDEADBEEF; exp_last = w;
    n_checks++;
    if ({o.g, o.addr_first, o.wm_first} !== {w, 21'h00010, 4'b0000}) begin
      n_fail++; $display("FAIL read_cmd: got g=%0d addr=%h wm=%h expected g=%0d addr=00010 wm=0", o.g, o.addr_first, o.wm_first, w);
    end
    n_checks++;
    if ({o.sv_busy, o.sv_at_s, o.early_rdy} !== 3'b100) begin
      n_fail++; $display("FAIL read_svalid: got busy/at_s/early=%b expected 100", {o.sv_busy, o.sv_at_s, o.early_rdy});
    end
    n_checks++;
    if ({o.r0, o.r1, o.r0_after, o.r1_after} !== 4'b1000) begin
      n_fail++; $display("FAIL read_ready: got r0,r1,r0+1,r1+1=%b expected 1000", {o.r0, o.r1, o.r0_after, o.r1_after});
    end
    n_checks++;
    if ({o.rd0, o.rd1} !== {exp_rdata[0], exp_rdata[1]}) begin
      n_fail++; $display("FAIL read_rdata: got rd0=%h rd1=%h expected rd0=%h rd1=%h", o.rd0, o.rd1, exp_rdata[0], exp_rdata[1]);
    end
    $display("single_read: m0 addr=00010 rdata=%h ready=%b", o.rd0, o.r0);
  endtask

  task automatic test_cmd_stability();
    obs_t o;
    logic [31:0] d;
    req_addr[1] = 21'h1FFFFF; req_wdata[1] = 32'h12345678; req_wstrb[1] = 4'b0011;
    m0_valid = 1'b0; m1_valid = 1'b1;
    d = $urandom;
    txn(5, d, 1'b0, o);
    exp_rdata[1] = d; exp_last = 1'b1;
    n_checks++;
    if ({o.addr_first, o.din_first, o.wm_first} !== {21'h1FFFFF, 32'h12345678, 4'b0011}) begin
      n_fail++; $display("FAIL stab_first: got %h/%h/%h expected 1fffff/12345678/3", o.addr_first, o.din_first, o.wm_first);
    end
    n_checks++;
    if ({o.addr_last, o.din_last, o.wm_last} !== {21'h1FFFFF, 32'h12345678, 4'b0011}) begin
      n_fail++; $display("FAIL stab_last: got %h/%h/%h expected 1fffff/12345678/3", o.addr_last, o.din_last, o.wm_last);
    end
    n_checks++;
    if (o.cmd_hold !== 1'b1) begin
      n_fail++; $display("FAIL stab_hold: command changed during BUSY (hold=%b) expected 1", o.cmd_hold);
    end
    n_checks++;
    if ({o.g, o.r1, o.r0, o.rd1} !== {1'b1, 1'b1, 1'b0, d}) begin
      n_fail++; $display("FAIL stab_resp: got g=%0d r1=%b r0=%b rd1=%h expected 1 1 0 %h", o.g, o.r1, o.r0, o.rd1, d);
    end
    $display("cmd_stability: m1 addr=%h din=%h wm=%h", o.addr_last, o.din_last, o.wm_last);
  endtask

  task automatic test_handshake();
    obs_t o, o2;
    bit w, w2;
    logic [31:0] d, d2;
    new_req(0); new_req(1);
    w = pick(1'b1, 1'b1, exp_last, 1'b0);
    d = $urandom;
    txn($urandom_range(1, 4), d, 1'b0, o);
    exp_rdata[w] = d; exp_last = w;
    n_checks++;
    if (o.g !== w) begin
      n_fail++; $display("FAIL hs_grant: got %0d expected %0d", o.g, w);
    end
    n_checks++;
    if (o.sv_at_s !== 1'b0) begin
      n_fail++; $display("FAIL hs_sv_at_s: got %b expected 0", o.sv_at_s);
    end
    n_checks++;
    if ({o.r1, o.r0} !== (w ? 2'b10 : 2'b01)) begin
      n_fail++; $display("FAIL hs_ready_s1: got r1r0=%b expected %b", {o.r1, o.r0}, (w ? 2'b10 : 2'b01));
    end
    n_checks++;
    if ({o.busy_resp, o.busy_idle, o.sv_idle} !== 3'b100) begin
      n_fail++; $display("FAIL hs_s2_idle: got busy@S+1,busy@S+2,sv@S+2=%b expected 100", {o.busy_resp, o.busy_idle, o.sv_idle});
    end
    w2 = !w;
    d2 = $urandom;
    txn($urandom_range(0, 3), d2, 1'b0, o2);
    exp_rdata[w2] = d2; exp_last = w2;
    n_checks++;
    if ({o2.sv_first, o2.g} !== {1'b1, w2}) begin
      n_fail++; $display("FAIL hs_next: got sv@S+3=%b g=%0d expected 1 %0d", o2.sv_first, o2.g, w2);
    end
    $display("handshake: first grant=%0d, pending grant=%0d", o.g, o2.g);
  endtask

  task automatic test_drop_valid();
    obs_t o;
    logic [31:0] d;
    new_req(0); m1_valid = 1'b0;
    d = $urandom;
    txn(3, d, 1'b1, o);
    exp_rdata[0] = d; exp_last = 1'b0;
    n_checks++;
    if ({o.r0, o.r0_after, o.rd0} !== {1'b1, 1'b0, d}) begin
      n_fail++; $display("FAIL drop_valid: got r0=%b r0+1=%b rd0=%h expected 1 0 %h", o.r0, o.r0_after, o.rd0, d);
    end
    $display("drop_valid: m0 dropped valid in BUSY, ready=%b rdata=%h", o.r0, o.rd0);
  endtask

  task automatic test_spurious();
    obs_t o;
    logic bad;
    logic [31:0] d;
    bad = 1'b0;
    m0_valid = 1'b0; m1_valid = 1'b0;
    repeat (6) begin
      s_ready = 1'b1; s_dout = $urandom;
      tick();
      if ({m0_ready, m1_ready, busy, s_valid} !== 4'b0) bad = 1'b1;
      s_ready = 1'b0;
      tick();
      if ({m0_ready, m1_ready, busy, s_valid} !== 4'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL spur_quiet: response to s_ready in IDLE (r0=%b r1=%b busy=%b) expected none", m0_ready, m1_ready, busy);
    end
    n_checks++;
    if ({m0_rdata, m1_rdata} !== {exp_rdata[0], exp_rdata[1]}) begin
      n_fail++; $display("FAIL spur_rdata: got %h/%h expected %h/%h", m0_rdata, m1_rdata, exp_rdata[0], exp_rdata[1]);
    end
    new_req(1);
    d = $urandom;
    txn(1, d, 1'b0, o);
    exp_rdata[1] = d; exp_last = 1'b1;
    n_checks++;
    if ({o.sv_first, o.g, o.r1, o.rd1} !== {1'b1, 1'b1, 1'b1, d}) begin
      n_fail++; $display("FAIL spur_after: got sv=%b g=%0d r1=%b rd1=%h expected 1 1 1 %h", o.sv_first, o.g, o.r1, o.rd1, d);
    end
    $display("spurious: 6 stray s_ready pulses in IDLE ignored");
  endtask

  task automatic test_simultaneous();
    obs_t o;
    bit w;
    logic [31:0] d;
    apply_reset();
    for (int r = 0; r < 6; r++) begin
      new_req(0); new_req(1);
      w = pick(1'b1, 1'b1, exp_last, 1'b0);
      d = $urandom;
      txn($urandom_range(0, 3), d, 1'b0, o);
      exp_rdata[w] = d; exp_last = w;
      n_checks++;
      if ({o.g, o.fp_g} !== {w, 1'b0}) begin
        n_fail++; $display("FAIL simul_grant round %0d: got rr=%0d fp=%0d expected rr=%0d fp=0", r, o.g, o.fp_g, w);
      end
      n_checks++;
      if ({o.r1, o.r0, o.rd0, o.rd1} !== {w, !w, exp_rdata[0], exp_rdata[1]}) begin
        n_fail++; $display("FAIL simul_resp round %0d: got r1r0=%b%b rd0=%h rd1=%h expected %b%b %h %h", r, o.r1, o.r0, o.rd0, o.rd1, w, !w, exp_rdata[0], exp_rdata[1]);
      end
      $display("simultaneous round %0d: rr grant=%0d fp grant=%0d", r, o.g, o.fp_g);
    end
  endtask

  task automatic test_random();
    obs_t o;
    bit w;
    int lat;
    logic [31:0] d;
    for (int it = 0; it < 40; it++) begin
      if (!m0_valid && $urandom_range(0, 1) == 1) new_req(0);
      if (!m1_valid && $urandom_range(0, 1) == 1) new_req(1);
      if (!m0_valid && !m1_valid) new_req($urandom_range(0, 1));
      w = pick(m0_valid, m1_valid, exp_last, 1'b0);
      lat = $urandom_range(0, 4);
      d = $urandom;
      txn(lat, d, 1'b0, o);
      exp_rdata[w] = d; exp_last = w;
      n_checks++;
      if (o.g !== w) begin
        n_fail++; $display("FAIL rand_grant it %0d: got %0d expected %0d", it, o.g, w);
      end
      n_checks++;
      if ({o.addr_first, o.din_first, o.wm_first, o.addr_last, o.din_last, o.wm_last, o.cmd_hold} !==
          {req_addr[w], req_wdata[w], req_wstrb[w], req_addr[w], req_wdata[w], req_wstrb[w], 1'b1}) begin
        n_fail++; $display("FAIL rand_cmd it %0d: got %h/%h/%h hold=%b expected %h/%h/%h", it, o.addr_first, o.din_first, o.wm_first, o.cmd_hold, req_addr[w], req_wdata[w], req_wstrb[w]);
      end
      n_checks++;
      if ({o.sv_first, o.sv_busy, o.sv_at_s, o.early_rdy, o.busy_resp, o.busy_idle, o.sv_idle} !== 7'b1100100) begin
        n_fail++; $display("FAIL rand_timing it %0d: got %b expected 1100100", it, {o.sv_first, o.sv_busy, o.sv_at_s, o.early_rdy, o.busy_resp, o.busy_idle, o.sv_idle});
      end
      n_checks++;
      if ({o.r1, o.r0, o.r1_after, o.r0_after, o.rd1, o.rd0} !== {w, !w, 2'b00, exp_rdata[1], exp_rdata[0]}) begin
        n_fail++; $display("FAIL rand_resp it %0d: got r=%b%b%b%b rd1=%h rd0=%h expected %b%b00 %h %h", it, o.r1, o.r0, o.r1_after, o.r0_after, o.rd1, o.rd0, w, !w, exp_rdata[1], exp_rdata[0]);
      end
      $display("random it %0d: grant=%0d lat=%0d addr=%h rdata=%h", it, o.g, lat, o.addr_first, d);
    end
  endtask

  task automatic test_reset_mid_busy();
    obs_t o;
    logic bad;
    logic [31:0] d;
    // Complete an m0 transaction first, so the pointer holds 0 before reset.
    m0_valid = 1'b0; m1_valid = 1'b0;
    tick();
    new_req(0);
    d = $urandom;
    txn(1, d, 1'b0, o);
    exp_rdata[0] = d; exp_last = 1'b0;
    new_req(1);
    drive_reqs();
    tick();
    n_checks++;
    if ({s_valid, busy, grant} !== 3'b111) begin
      n_fail++; $display("FAIL rmb_pre: got sv/busy/grant=%b expected 111", {s_valid, busy, grant});
    end
    #3; resetn = 1'b0; #1;
    n_checks++;
    if ({s_valid, busy, grant, m0_rdata} !== {3'b000, 32'h0}) begin
      n_fail++; $display("FAIL rmb_async: got sv/busy/grant=%b rd0=%h expected 000 0", {s_valid, busy, grant}, m0_rdata);
    end
    m1_valid = 1'b0; s_ready = 1'b1;
    @(posedge clk); #2;
    resetn = 1'b1; s_ready = 1'b0;
    exp_last = 1'b1; exp_rdata[0] = '0; exp_rdata[1] = '0;
    bad = 1'b0;
    repeat (4) begin
      tick();
      if ({m0_ready, m1_ready, busy, s_valid} !== 4'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL rmb_no_pulse: activity after reset (r0=%b r1=%b busy=%b) expected none", m0_ready, m1_ready, busy);
    end
    new_req(0); new_req(1);
    d = $urandom;
    txn(2, d, 1'b0, o);
    n_checks++;
    if ({o.g, o.r0, o.rd0} !== {pick(1'b1, 1'b1, exp_last, 1'b0), 1'b1, d}) begin
      n_fail++; $display("FAIL rmb_rearb: got g=%0d r0=%b rd0=%h expected 0 1 %h", o.g, o.r0, o.rd0, d);
    end
    $display("reset_mid_busy: m1 transaction discarded, re-arbitration grant=%0d", o.g);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle();
    test_single_read();
    test_cmd_stability();
    test_handshake();
    test_drop_valid();
    test_spurious();
    test_simultaneous();
    test_random();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 21, giving the word-address width of requester and SDRAM-controller ports.
REQ-002 The block SHALL have parameter PRIO_M0, default 0; 1 = fixed priority to m0, 0 = round-robin.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 m0_valid / m1_valid  input  1 each  request from requester 0 (CPU) / 1 (DMA/video), held until that requester's ready.
REQ-006 m0_addr / m1_addr  input  ADDR_WIDTH each  word address.
REQ-007 m0_wdata / m1_wdata  input  32 each  write data.
REQ-008 m0_wstrb / m1_wstrb  input  4 each  byte write strobes; 4'b0000 = read.
REQ-009 m0_ready / m1_ready  output  1 each  one-cycle completion pulse to the requester.
REQ-010 m0_rdata / m1_rdata  output  32 each  read data, valid while the matching ready is high.
REQ-011 s_valid  output  1  request to the SDRAM controller.
REQ-012 s_addr, s_din, s_wmask  output  ADDR_WIDTH, 32, 4  latched command to the controller.
REQ-013 s_ready  input  1  one-cycle controller completion; s_dout  input  32  read data, valid with s_ready.
REQ-014 grant  output  1  index of the requester currently owning the controller; busy  output  1  high in BUSY and RESP.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY, RESP and no others.
REQ-016 In IDLE with at least one valid, the block SHALL select a winner, latch its addr/wdata/wstrb into s_addr/s_din/s_wmask, set grant, and enter BUSY on the next edge.
REQ-017 Round-robin (PRIO_M0=0): on simultaneous m0_valid and m1_valid, the winner SHALL be the requester not granted last; after reset the last-granted pointer SHALL be 1, so m0 wins first.
REQ-018 Fixed priority (PRIO_M0=1): m0 SHALL win every simultaneous request.
REQ-019 A single valid SHALL be granted regardless of the pointer.
REQ-020 s_valid SHALL equal (state==BUSY) AND NOT s_ready, so it is low in the s_ready cycle.
REQ-021 The latched command SHALL stay stable throughout BUSY, independent of later requester inputs.
REQ-022 On s_ready in BUSY, the block SHALL register s_dout into the granted requester's rdata and enter RESP.
REQ-023 In RESP the block SHALL pulse the granted requester's ready for exactly one cycle, update the last-granted pointer, and return to IDLE.
REQ-024 The non-granted requester's ready SHALL stay 0 and its rdata SHALL hold its previous value.
REQ-025 Latency SHALL be fixed: valid seen in IDLE at cycle T gives s_valid at T+1; s_ready at cycle S gives requester ready at S+1.
REQ-026 Minimum back-to-back spacing SHALL be one IDLE cycle after each RESP; a request still asserted in RESP SHALL NOT be granted in RESP.
REQ-027 A requester dropping valid during BUSY SHALL NOT abort the transaction: the transaction completes and ready is still pulsed.
REQ-028 s_ready outside BUSY SHALL be ignored, with no state change and no ready pulse.
REQ-029 With no requests, the block SHALL remain in IDLE with s_valid=0 indefinitely.

Reset
REQ-030 Asserting resetn low SHALL immediately force: state IDLE, s_valid 0, m0_ready/m1_ready 0, grant 0, busy 0, last-granted pointer 1, s_addr/s_din/s_wmask/m*_rdata 0.
REQ-031 Reset asserted mid-BUSY SHALL discard the transaction with no ready pulse; the first post-reset request SHALL be re-arbitrated from IDLE.
REQ-032 Release of resetn SHALL take effect at the first clock edge after deassertion, with no output glitch during reset.

Verification
REQ-033 Single read: m0 addr 0x00010, wstrb 0. Controller returns s_ready with s_dout 0xDEADBEEF 3 cycles after s_valid. Required: m0_ready is one cycle, m0_rdata=0xDEADBEEF, and m1 outputs are unchanged.
REQ-034 Simultaneous requests: m0 and m1 both valid from reset, repeatedly. Required: grants alternate 0,1,0,1 with PRIO_M0=0; with PRIO_M0=1, m0 is always granted while its valid is held.
REQ-035 Command stability: m1 write addr 0x1FFFFF, wdata 0x12345678, wstrb 4'b0011; m1 changes addr/wdata mid-BUSY. Required: s_addr, s_din and s_wmask hold 0x1FFFFF, 0x12345678 and 4'b0011 until s_ready.
REQ-036 Handshake timing: s_ready at cycle S. Required: s_valid=0 at S, m_ready=1 at S+1, state IDLE at S+2, and the next s_valid no earlier than S+3.
REQ-037 Reset mid-BUSY: resetn pulsed low asynchronously between clock edges. Required: s_valid and busy go to 0 before the next edge, and no ready pulse follows.
REQ-038 Spurious s_ready in IDLE: s_ready asserted with no requests pending. Required: no ready pulse, and state stays IDLE.
